// File: rtl/overlap_accum_if.sv
// rtl/overlap_accum_if.sv - segment input / result output handshake bundle for overlap_accum
interface overlap_accum_if #(
    parameter int W  = 21,
    parameter int OW = 43
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    // Producer/consumer side (testbench or upstream logic)
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/overlap_accum.sv
// rtl/overlap_accum.sv - GF(2) overlapped XOR accumulation of K partial-product segments
module overlap_accum #(
    parameter int  W  = 21,
    parameter int  S  = 11,
    parameter int  K  = 3,
    localparam int OW = (K - 1) * S + W,
    localparam int CW = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    overlap_accum_if.slave bus,
    output logic [CW-1:0] seg_cnt
);

    generate
        if (S < 1 || S > W || K < 2) begin : g_bad_params
            $error("overlap_accum: need 1 <= S <= W and K >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [OW-1:0] acc;
    logic [OW-1:0] acc_next;
    logic [OW-1:0] seg_term;
    logic [CW-1:0] cnt_next;
    logic          xfer;
    logic          out_xfer;

    // Handshake outputs decode from registered state only
    assign bus.in_ready  = (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = (state == DONE) ? acc : '0;
    assign xfer          = bus.in_valid && bus.in_ready;
    assign out_xfer      = bus.out_valid && bus.out_ready;

    // Place the incoming segment at the offset of its index; other bits stay zero
    always_comb begin
        seg_term = '0;
        for (int i = 0; i < K; i++) begin
            if (seg_cnt == CW'(i)) begin
                seg_term[i*S +: W] = bus.in_data;
            end
        end
    end

    // Next-state, accumulator and segment counter decision
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = seg_cnt;
        case (state)
            IDLE, ACCUM: begin
                if (abort) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                end else if (xfer) begin
                    acc_next   = acc ^ seg_term;
                    cnt_next   = seg_cnt + CW'(1);
                    state_next = (seg_cnt == CW'(K - 1)) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_xfer) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // State, accumulator and counter registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            seg_cnt <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            seg_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_overlap_accum.sv
// tb/tb_overlap_accum.sv - self-checking bench for overlap_accum
module tb_overlap_accum;
    localparam int W  = 21;
    localparam int S  = 11;
    localparam int K  = 3;
    localparam int OW = (K - 1) * S + W;
    localparam int CW = $clog2(K + 1);

    localparam logic [OW-1:0] ONES_EXP = 43'h7FF002007FF;
    localparam logic [OW-1:0] BITS_EXP = 43'h40000000801;
    localparam logic [W-1:0]  ONES     = {W{1'b1}};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] seg_cnt;
    int            n_pass  = 0;
    int            n_total = 0;

    overlap_accum_if #(.W(W), .OW(OW)) bus ();

    overlap_accum #(.W(W), .S(S), .K(K)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (abort),
        .bus     (bus.slave),
        .seg_cnt (seg_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] ref_result(input logic [W-1:0] segs[$]);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < segs.size(); i++) begin
            r = r ^ (OW'(segs[i]) << (i * S));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        abort         = 1'b0;
        #12;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (seg_cnt !== '0) $display("FAIL reset_seg_cnt got %0d want 0", seg_cnt);
        else n_pass++;
        n_total++;
        if (bus.out_data !== '0) $display("FAIL reset_out_data got %h want 0", bus.out_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_ones();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = ONES;
        tick();
        tick();
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL ones_early_valid got %b want 0", bus.out_valid);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL ones_out_valid got %b want 1", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.out_data !== ONES_EXP) $display("FAIL ones_out_data got %h want %h", bus.out_data, ONES_EXP);
        else n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL ones_drop_valid got %b want 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.out_data !== '0) $display("FAIL ones_idle_data got %h want 0", bus.out_data);
        else n_pass++;
        n_total++;
        if (seg_cnt !== '0) $display("FAIL ones_idle_cnt got %0d want 0", seg_cnt);
        else n_pass++;
    endtask

    task automatic test_single_bits();
        logic [W-1:0] segs[$];
        segs = '{21'h000001, 21'h000001, 21'h100000};
        bus.out_ready = 1'b0;
        for (int i = 0; i < K; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = segs[i];
            tick();
            n_total++;
            if (seg_cnt !== CW'(i + 1)) $display("FAIL bits_seg_cnt%0d got %0d want %0d", i, seg_cnt, i + 1);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_data !== BITS_EXP) $display("FAIL bits_out_data got %h want %h", bus.out_data, BITS_EXP);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [W-1:0]  segs[$];
        logic [OW-1:0] exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < K; i++) begin
            segs.push_back(W'($urandom));
            bus.in_valid = 1'b1;
            bus.in_data  = segs[i];
            tick();
        end
        exp = ref_result(segs);
        for (int j = 0; j < 5; j++) begin
            bus.in_data = W'($urandom);
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready%0d got %b want 0", j, bus.in_ready);
            else n_pass++;
            n_total++;
            if (bus.out_data !== exp) $display("FAIL hold_out_data%0d got %h want %h", j, bus.out_data, exp);
            else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL hold_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_total++;
        if (seg_cnt !== CW'(1)) $display("FAIL hold_next_accept got %0d want 1", seg_cnt);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_data = W'($urandom);
            tick();
        end
        abort       = 1'b1;
        bus.in_data = W'($urandom);
        tick();
        abort = 1'b0;
        n_total++;
        if (seg_cnt !== '0) $display("FAIL abort_seg_cnt got %0d want 0", seg_cnt);
        else n_pass++;
        bus.in_data = ONES;
        for (int i = 0; i < K; i++) tick();
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_data !== ONES_EXP) $display("FAIL abort_out_data got %h want %h", bus.out_data, ONES_EXP);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL abort_in_done got valid=%b want 1", bus.out_valid);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midway();
        logic [W-1:0] segs[$];
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'($urandom);
        tick();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || seg_cnt !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_accum got valid=%b cnt=%0d ready=%b want 0 0 1", bus.out_valid, seg_cnt, bus.in_ready);
        else n_pass++;
        #1 rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        for (int i = 0; i < K; i++) begin
            bus.in_data = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_done got %b want 1", bus.out_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || seg_cnt !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_done got valid=%b cnt=%0d ready=%b want 0 0 1", bus.out_valid, seg_cnt, bus.in_ready);
        else n_pass++;
        segs.push_back(W'($urandom));
        bus.in_valid = 1'b1;
        bus.in_data  = segs[0];
        #1 rst_n = 1'b1;
        tick();
        n_total++;
        if (seg_cnt !== CW'(1)) $display("FAIL rst_first_accept got %0d want 1", seg_cnt);
        else n_pass++;
        for (int i = 1; i < K; i++) begin
            segs.push_back(W'($urandom));
            bus.in_data = segs[i];
            tick();
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_data !== ref_result(segs))
            $display("FAIL rst_after_data got %h want %h", bus.out_data, ref_result(segs));
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0]  segs[$];
        logic          iv;
        logic          orr;
        logic          ab;
        logic [W-1:0]  d;
        int            results;
        bit            done;
        results = 0;
        for (int cyc = 0; cyc < 90000 && results < 10000; cyc++) begin
            done = (segs.size() == K);
            n_total++;
            if (bus.out_valid !== done) $display("FAIL rnd_out_valid cyc%0d got %b want %b", cyc, bus.out_valid, done);
            else n_pass++;
            n_total++;
            if (bus.in_ready !== !done) $display("FAIL rnd_in_ready cyc%0d got %b want %b", cyc, bus.in_ready, !done);
            else n_pass++;
            n_total++;
            if (seg_cnt !== CW'(segs.size())) $display("FAIL rnd_seg_cnt cyc%0d got %0d want %0d", cyc, seg_cnt, segs.size());
            else n_pass++;
            if (!done) begin
                n_total++;
                if (bus.out_data !== '0) $display("FAIL rnd_idle_data cyc%0d got %h want 0", cyc, bus.out_data);
                else n_pass++;
            end
            iv  = ($urandom_range(3) != 0);
            orr = ($urandom_range(3) != 0);
            ab  = ($urandom_range(49) == 0);
            d   = W'($urandom);
            bus.in_valid  = iv;
            bus.in_data   = d;
            bus.out_ready = orr;
            abort         = ab;
            if (!done) begin
                if (ab) segs.delete();
                else if (iv) segs.push_back(d);
            end else if (orr) begin
                n_total++;
                if (bus.out_data !== ref_result(segs))
                    $display("FAIL rnd_result%0d got %h want %h", results, bus.out_data, ref_result(segs));
                else n_pass++;
                results++;
                segs.delete();
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        abort         = 1'b0;
        n_total++;
        if (results != 10000) $display("FAIL rnd_result_count got %0d want 10000", results);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_bits();
        test_hold();
        test_abort();
        test_reset_midway();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
